// File: rtl/pipe_control.sv
// Main control decoder and load-use hazard unit for a 5-stage MIPS pipeline.
// Decoded controls travel through ID/EX, EX/MEM and MEM/WB with their instruction.
module pipe_control #(
    parameter int OPCODE_WIDTH = 6,
    parameter int AWIDTH       = 5
) (
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    c_i_ce,
    input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
    input  logic [OPCODE_WIDTH-1:0] c_i_funct,
    input  logic [AWIDTH-1:0]       c_i_rs,
    input  logic [AWIDTH-1:0]       c_i_rt,
    input  logic [AWIDTH-1:0]       c_i_rd,
    input  logic                    c_i_flush,
    output logic                    c_o_stall,
    output logic                    c_o_RegDst,
    output logic                    c_o_ALUSrc,
    output logic                    c_o_Branch,
    output logic [3:0]              c_o_ALUCtl,
    output logic                    c_o_MemRead,
    output logic                    c_o_MemWrite,
    output logic                    c_o_RegWrite,
    output logic                    c_o_MemtoReg,
    output logic [AWIDTH-1:0]       c_o_ex_waddr,
    output logic [AWIDTH-1:0]       c_o_mem_waddr,
    output logic [AWIDTH-1:0]       c_o_wb_waddr,
    output logic                    c_o_illegal
);

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);

    localparam logic [OPCODE_WIDTH-1:0] FN_ADD = OPCODE_WIDTH'(6'b100000);
    localparam logic [OPCODE_WIDTH-1:0] FN_SUB = OPCODE_WIDTH'(6'b100010);
    localparam logic [OPCODE_WIDTH-1:0] FN_AND = OPCODE_WIDTH'(6'b100100);
    localparam logic [OPCODE_WIDTH-1:0] FN_OR  = OPCODE_WIDTH'(6'b100101);
    localparam logic [OPCODE_WIDTH-1:0] FN_SLT = OPCODE_WIDTH'(6'b101010);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic              w_regDst, w_aluSrc, w_branch;
    logic [3:0]        w_aluCtl;
    logic              w_memRead, w_memWrite, w_regWrite, w_memtoReg;
    logic [AWIDTH-1:0] w_waddr;
    logic              w_isRtype, w_usesRt, w_illegal;
    logic              w_stall, w_bubble;

    logic              r_ex_regDst, r_ex_aluSrc, r_ex_branch;
    logic [3:0]        r_ex_aluCtl;
    logic              r_ex_memRead, r_ex_memWrite, r_ex_regWrite, r_ex_memtoReg;
    logic [AWIDTH-1:0] r_ex_waddr;
    logic              r_mem_memRead, r_mem_memWrite, r_mem_regWrite, r_mem_memtoReg;
    logic [AWIDTH-1:0] r_mem_waddr;
    logic              r_wb_regWrite, r_wb_memtoReg;
    logic [AWIDTH-1:0] r_wb_waddr;
    logic              r_illegal;

    always_comb begin
        w_regDst   = 1'b0;
        w_aluSrc   = 1'b0;
        w_branch   = 1'b0;
        w_aluCtl   = ALU_AND;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_regWrite = 1'b0;
        w_memtoReg = 1'b0;
        w_isRtype  = 1'b0;
        w_usesRt   = 1'b0;
        w_illegal  = 1'b0;
        case (c_i_opcode)
            OP_RTYPE: begin
                w_isRtype = 1'b1;
                w_usesRt  = 1'b1;
                w_regDst  = 1'b1;
                w_regWrite = 1'b1;
                case (c_i_funct)
                    FN_ADD:  w_aluCtl = ALU_ADD;
                    FN_SUB:  w_aluCtl = ALU_SUB;
                    FN_AND:  w_aluCtl = ALU_AND;
                    FN_OR:   w_aluCtl = ALU_OR;
                    FN_SLT:  w_aluCtl = ALU_SLT;
                    default: begin
                        w_regDst   = 1'b0;
                        w_regWrite = 1'b0;
                        w_illegal  = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                w_aluSrc   = 1'b1;
                w_memRead  = 1'b1;
                w_memtoReg = 1'b1;
                w_regWrite = 1'b1;
                w_aluCtl   = ALU_ADD;
            end
            OP_SW: begin
                w_usesRt   = 1'b1;
                w_aluSrc   = 1'b1;
                w_memWrite = 1'b1;
                w_aluCtl   = ALU_ADD;
            end
            OP_BEQ: begin
                w_usesRt = 1'b1;
                w_branch = 1'b1;
                w_aluCtl = ALU_SUB;
            end
            OP_ADDI: begin
                w_aluSrc   = 1'b1;
                w_regWrite = 1'b1;
                w_aluCtl   = ALU_ADD;
            end
            default: w_illegal = 1'b1;
        endcase
        // Non-writing instructions carry waddr 0 so they can never match the hazard check.
        if (!w_regWrite)
            w_waddr = '0;
        else if (w_isRtype)
            w_waddr = c_i_rd;
        else
            w_waddr = c_i_rt;
    end

    assign w_stall = r_ex_memRead && (r_ex_waddr != '0) &&
                     ((r_ex_waddr == c_i_rs) || (w_usesRt && (r_ex_waddr == c_i_rt)));
    assign w_bubble = w_stall | c_i_flush;

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            r_ex_regDst    <= 1'b0;
            r_ex_aluSrc    <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_aluCtl    <= '0;
            r_ex_memRead   <= 1'b0;
            r_ex_memWrite  <= 1'b0;
            r_ex_regWrite  <= 1'b0;
            r_ex_memtoReg  <= 1'b0;
            r_ex_waddr     <= '0;
            r_mem_memRead  <= 1'b0;
            r_mem_memWrite <= 1'b0;
            r_mem_regWrite <= 1'b0;
            r_mem_memtoReg <= 1'b0;
            r_mem_waddr    <= '0;
            r_wb_regWrite  <= 1'b0;
            r_wb_memtoReg  <= 1'b0;
            r_wb_waddr     <= '0;
            r_illegal      <= 1'b0;
        end else if (c_i_ce) begin
            r_ex_regDst    <= w_bubble ? 1'b0 : w_regDst;
            r_ex_aluSrc    <= w_bubble ? 1'b0 : w_aluSrc;
            r_ex_branch    <= w_bubble ? 1'b0 : w_branch;
            r_ex_aluCtl    <= w_bubble ? 4'b0000 : w_aluCtl;
            r_ex_memRead   <= w_bubble ? 1'b0 : w_memRead;
            r_ex_memWrite  <= w_bubble ? 1'b0 : w_memWrite;
            r_ex_regWrite  <= w_bubble ? 1'b0 : w_regWrite;
            r_ex_memtoReg  <= w_bubble ? 1'b0 : w_memtoReg;
            r_ex_waddr     <= w_bubble ? '0 : w_waddr;
            r_mem_memRead  <= r_ex_memRead;
            r_mem_memWrite <= r_ex_memWrite;
            r_mem_regWrite <= r_ex_regWrite;
            r_mem_memtoReg <= r_ex_memtoReg;
            r_mem_waddr    <= r_ex_waddr;
            r_wb_regWrite  <= r_mem_regWrite;
            r_wb_memtoReg  <= r_mem_memtoReg;
            r_wb_waddr     <= r_mem_waddr;
            // A killed illegal instruction never executes, so it must not raise the flag.
            if (w_illegal && !w_bubble)
                r_illegal <= 1'b1;
        end
    end

    assign c_o_stall     = w_stall;
    assign c_o_RegDst    = r_ex_regDst;
    assign c_o_ALUSrc    = r_ex_aluSrc;
    assign c_o_Branch    = r_ex_branch;
    assign c_o_ALUCtl    = r_ex_aluCtl;
    assign c_o_ex_waddr  = r_ex_waddr;
    assign c_o_MemRead   = r_mem_memRead;
    assign c_o_MemWrite  = r_mem_memWrite;
    assign c_o_mem_waddr = r_mem_waddr;
    assign c_o_RegWrite  = r_wb_regWrite;
    assign c_o_MemtoReg  = r_wb_memtoReg;
    assign c_o_wb_waddr  = r_wb_waddr;
    assign c_o_illegal   = r_illegal;

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined main-control and load-use hazard unit for the MIPS datapath. It decodes the opcode and funct of the instruction in the decode stage. It carries the resulting control bundle through the ID/EX, EX/MEM and MEM/WB registers, so each datapath stage sees the controls of the instruction it holds. It also detects load-use hazards and inserts bubbles.

## Interface
- OPCODE_WIDTH, 6, opcode/funct width
- AWIDTH, 5, register address width
- c_clk  in  1  clock, rising edge
- c_rst  in  1  reset, asynchronous, active-low
- c_i_ce  in  1  pipeline advance enable; 0 holds all stage registers
- c_i_opcode  in  6  decode-stage opcode (instr[31:26])
- c_i_funct  in  6  decode-stage funct (instr[5:0])
- c_i_rs, c_i_rt, c_i_rd  in  5 each  decode-stage register fields
- c_i_flush  in  1  taken branch: kill the decode-stage instruction
- c_o_stall  out  1  load-use hazard: hold PC and IF/ID
- c_o_RegDst, c_o_ALUSrc, c_o_Branch  out  1 each  EX-stage controls
- c_o_ALUCtl  out  4  EX-stage ALU operation
- c_o_MemRead, c_o_MemWrite  out  1 each  MEM-stage controls
- c_o_RegWrite, c_o_MemtoReg  out  1 each  WB-stage controls
- c_o_ex_waddr, c_o_mem_waddr, c_o_wb_waddr  out  5 each  destination register per stage
- c_o_illegal  out  1  sticky: an undefined opcode/funct was decoded

## Operation
Combinational decode. Unlisted opcodes produce all-zero controls and set illegal.
- R-type (000000): RegDst=1, RegWrite=1.
  - funct 100000 → ADD=0010
  - funct 100010 → SUB=0110
  - funct 100100 → AND=0000
  - funct 100101 → OR=0001
  - funct 101010 → SLT=0111
  - any other funct → all-zero controls and illegal
- lw (100011): ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ADD.
- sw (101011): ALUSrc=1, MemWrite=1, ADD.
- beq (000100): Branch=1, SUB.
- addi (001000): ALUSrc=1, RegWrite=1, ADD.

Destination address:
- R-type → rd.
- All others → rt.
- Forced to 0 when RegWrite=0.

Hazard detection:
- c_o_stall = ID/EX.MemRead & (ID/EX.waddr != 0) & ((ID/EX.waddr == c_i_rs) | (uses_rt & ID/EX.waddr == c_i_rt)).
- uses_rt = R-type | sw | beq.
- c_o_stall is combinational from the ID/EX register and the decode inputs.

Pipeline registers, on a c_clk rising edge with c_i_ce=1:
- ID/EX loads the decode result, or a bubble when c_o_stall | c_i_flush.
- EX/MEM ← ID/EX.
- MEM/WB ← EX/MEM.

Other rules:
- Bubble = all controls 0, waddr 0.
- Outputs are driven directly from the stage registers: ID/EX → EX-stage outputs, EX/MEM → MEM-stage outputs, MEM/WB → WB-stage outputs.
- c_i_ce=0: all registers hold, c_o_illegal holds, and c_o_stall still reflects the current state.
- c_i_flush together with c_o_stall: a bubble is inserted and c_o_stall remains asserted as computed. The upstream flush logic has priority over stall for PC update.
- c_o_illegal sets on the edge at which an illegal instruction enters ID/EX, and only when it is not bubbled. It clears only on reset.

## Timing
- Reset (c_rst=0, asynchronous): all stage registers and c_o_illegal clear to 0, so every output is 0 and c_o_stall is 0. Release is synchronous to the next rising edge.
- Latency, with c_i_ce held at 1:
  - instruction present at decode during cycle N
  - EX controls valid in cycle N+1
  - MEM controls valid in cycle N+2
  - WB controls valid in cycle N+3
- A stall lasts exactly one cycle per load-use pair. After the bubble, ID/EX holds no load, so c_o_stall drops unless the next ID/EX content is itself a matching load.
- A reset asserted mid-pipeline discards all in-flight controls immediately, without waiting for a clock.

## Test plan
- Reset with c_rst=0 for 2 cycles, then apply lw $6,20($7) (opcode 100011, rt=6):
  - all outputs 0 during reset
  - after 1 edge: ALUSrc=1, ALUCtl=0010, ex_waddr=6
  - after 2 edges: MemRead=1, mem_waddr=6
  - after 3 edges: RegWrite=1, MemtoReg=1, wb_waddr=6
- lw $6 followed by add $8,$6,$2:
  - c_o_stall=1 for 1 cycle
  - EX stage shows a bubble (all 0)
  - the add reaches EX one cycle later with RegDst=1, ALUCtl=0010, ex_waddr=8
- lw $6 followed by add $8,$2,$3: c_o_stall stays 0; sw $6 after lw $6 (rt match, uses_rt): c_o_stall=1.
- beq with c_i_flush=1 on the following instruction: the flushed slot produces all-zero EX controls, and the beq shows Branch=1, ALUCtl=0110.
- c_i_ce=0 for 3 cycles mid-stream: all stage outputs frozen, then resume unchanged.
- Opcode 111111, or R-type with funct 000111: all controls 0 and c_o_illegal=1, sticky until c_rst=0; asserting c_rst mid-stream clears every output asynchronously.
